// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: buffers two image lines and emits one window per valid
// position over valid/ready. Optional macro OVERRUN_CHECK_EN drains and flags stray pixels.
module sobel_window_gen #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 640,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [15:0]         W,
  input  logic [15:0]         H,
  input  logic [DATA_W-1:0]   pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [9*DATA_W-1:0] win,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [15:0]         win_x,
  output logic [15:0]         win_y,
  output logic                frame_done,
  output logic                busy,
  output logic [1:0]          err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  localparam logic [15:0] MAX_W16 = 16'(MAX_W);

  state_e                 state_q;
  logic [15:0]            w_q, h_q, x_q, y_q;
  logic [15:0]            win_x_q, win_y_q;
  logic [9*DATA_W-1:0]    win_q, win_d;
  logic                   win_valid_q, frame_done_q, busy_q, err_cfg_q;
  logic [2:0][DATA_W-1:0] col1_q, col2_q, col_new;
  logic [DATA_W-1:0]      ram_a [MAX_W];
  logic [DATA_W-1:0]      ram_b [MAX_W];
  logic [ADDR_W-1:0]      addr;
  logic                   accept, run_accept, last_x, cfg_bad;

  assign addr       = x_q[ADDR_W-1:0];
  assign accept     = pix_valid && pix_ready;
  assign run_accept = accept && (state_q == RUN);
  assign last_x     = (x_q == w_q - 16'd1);
  assign cfg_bad    = (W < 16'd3) || (H < 16'd3) || (W > MAX_W16);

  // Row 0 is the oldest line (RAM B), row 2 the incoming pixel.
  assign col_new = {pix_in, ram_a[addr], ram_b[addr]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win_d = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[DATA_W*(3*r+0) +: DATA_W] = col1_q[r];
      win_d[DATA_W*(3*r+1) +: DATA_W] = col2_q[r];
      win_d[DATA_W*(3*r+2) +: DATA_W] = col_new[r];
    end
  end

  always_comb begin
    pix_ready = 1'b0;
    case (state_q)
      RUN: pix_ready = !win_valid_q || win_ready;
`ifdef OVERRUN_CHECK_EN
      IDLE, DONE: pix_ready = rstn;
`endif
      default: pix_ready = 1'b0;
    endcase
  end

  // NOTE: line RAMs have no reset; stale words only reach columns the x>=2 / y>=2 gate discards.
  always_ff @(posedge clk) begin
    if (run_accept) begin
      ram_b[addr] <= ram_a[addr];
      ram_a[addr] <= pix_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      col1_q       <= '0;
      col2_q       <= '0;
      win_q        <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_cfg_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (win_ready) win_valid_q <= 1'b0;

      if (run_accept) begin
        col1_q <= col2_q;
        col2_q <= col_new;
        // A freshly produced window overrides the consumed one with no bubble.
        if (x_q >= 16'd2 && y_q >= 16'd2) begin
          win_valid_q <= 1'b1;
          win_q       <= win_d;
          win_x_q     <= x_q - 16'd2;
          win_y_q     <= y_q - 16'd2;
        end
        if (last_x) begin
          x_q <= '0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_cfg_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              w_q       <= W;
              h_q       <= H;
              x_q       <= '0;
              y_q       <= '0;
              err_cfg_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          if (run_accept && last_x && (y_q == h_q - 16'd1)) state_q <= FLUSH;
        end
        FLUSH: begin
          if (!win_valid_q || win_ready) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OVERRUN_CHECK_EN
  logic ovr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr_q <= 1'b0;
    end else if (state_q == IDLE && start && !cfg_bad) begin
      ovr_q <= 1'b0;
    end else if (accept && (state_q == IDLE || state_q == DONE)) begin
      ovr_q <= 1'b1;
    end
  end

  assign err = {ovr_q, err_cfg_q};
`else
  assign err = {1'b0, err_cfg_q};
`endif

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
